// File: rtl/chip8_mem_gpu_if.sv
// ----------------------------------------------------------------------------
// chip8_mem_gpu_if
// Groups every non-clock/reset signal of the CHIP-8 memory + GPU block:
//   CPU read port   : read, read_addr -> read_data, read_ack
//   CPU write port  : write, write_addr, write_data
//   GPU command     : gpu_cmd, gpu_draw_offset/x/y/length, gpu_cmd_submitted
//                     -> gpu_collision, gpu_ready
//   VGA scan-out    : vga_read, vga_addr -> vga_data
// master = CPU/VGA side (drives requests), slave = memory/GPU block.
// ----------------------------------------------------------------------------
interface chip8_mem_gpu_if;
  logic        read;
  logic [11:0] read_addr;
  logic [7:0]  read_data;
  logic        read_ack;
  logic        write;
  logic [11:0] write_addr;
  logic [7:0]  write_data;
  logic [3:0]  gpu_cmd;
  logic [11:0] gpu_draw_offset;
  logic [7:0]  gpu_draw_x;
  logic [7:0]  gpu_draw_y;
  logic [7:0]  gpu_draw_length;
  logic        gpu_cmd_submitted;
  logic        gpu_collision;
  logic        gpu_ready;
  logic        vga_read;
  logic [11:0] vga_addr;
  logic [7:0]  vga_data;

  modport master (
    output read, read_addr, write, write_addr, write_data,
           gpu_cmd, gpu_draw_offset, gpu_draw_x, gpu_draw_y, gpu_draw_length,
           gpu_cmd_submitted, vga_read, vga_addr,
    input  read_data, read_ack, gpu_collision, gpu_ready, vga_data
  );

  modport slave (
    input  read, read_addr, write, write_addr, write_data,
           gpu_cmd, gpu_draw_offset, gpu_draw_x, gpu_draw_y, gpu_draw_length,
           gpu_cmd_submitted, vga_read, vga_addr,
    output read_data, read_ack, gpu_collision, gpu_ready, vga_data
  );
endinterface

// File: rtl/chip8_mem_gpu.sv
// ----------------------------------------------------------------------------
// chip8_mem_gpu
// 4 KiB byte-addressed CHIP-8 RAM with an embedded 64x32 monochrome
// framebuffer (FB_BASE..FB_BASE+255, 8 bytes per row, bit 7 = leftmost
// pixel) and a small engine executing CLS and XOR sprite DRAW commands.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (RAM contents are kept)
//   bus  - chip8_mem_gpu_if.slave: CPU read/write ports, GPU command
//          handshake, VGA scan-out read port (see interface header)
// Parameters:
//   FB_BASE   - framebuffer base address
//   INIT_FILE - RAM image name for the target's memory-initialisation flow;
//               empty means an all-zero RAM
// The CPU port has priority on the shared internal port: any cycle with a
// CPU read or write stalls the engine, which retries the same step.
// ----------------------------------------------------------------------------
module chip8_mem_gpu #(
  parameter logic [11:0] FB_BASE   = 12'hF00,
  parameter              INIT_FILE = ""
) (
  input  logic clk,
  input  logic rst,
  chip8_mem_gpu_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, FETCH, READ_L, READ_R, WRITE_L, WRITE_R, NEXT, DONE
  } state_t;

  logic [7:0]  mem [0:4095];

  state_t      state_r;
  logic [11:0] offset_r;
  logic [5:0]  x0_r;
  logic [4:0]  y0_r;
  logic [3:0]  len_r;
  logic [3:0]  row_r;
  logic [7:0]  clr_cnt_r;
  logic [7:0]  sprite_r;
  logic [7:0]  left_old_r;
  logic [7:0]  gpu_rdata_r;
  logic        acc_r;
  logic        upd_r;

  logic [2:0]  sh_s;
  logic [2:0]  xb_s;
  logic [2:0]  xr_s;
  logic [4:0]  yr_s;
  logic [11:0] left_addr_s;
  logic [11:0] right_addr_s;
  logic [15:0] mask_s;
  logic [7:0]  lmask_s;
  logic [7:0]  rmask_s;
  logic        gpu_req_s;
  logic        gpu_we_s;
  logic [11:0] gpu_addr_s;
  logic [7:0]  gpu_wdata_s;
  logic        cpu_busy_s;
  logic        go_s;
  logic        mem_we_s;
  logic [11:0] mem_addr_s;
  logic [7:0]  mem_wdata_s;
  logic        unused_bits_s;

  // Coordinates/x-y bits beyond the wrap range are intentionally ignored.
  assign unused_bits_s = ^{bus.gpu_draw_x[7:6], bus.gpu_draw_y[7:5],
                           bus.gpu_draw_length[7:4]};

  // Sprite geometry: byte column, in-byte shift, wrapped row and masks.
  always_comb begin
    sh_s         = x0_r[2:0];
    xb_s         = x0_r[5:3];
    xr_s         = xb_s + 3'd1;                 // horizontal wrap within row
    yr_s         = y0_r + {1'b0, row_r};        // vertical wrap mod 32
    left_addr_s  = FB_BASE + {4'h0, yr_s, xb_s};
    right_addr_s = FB_BASE + {4'h0, yr_s, xr_s};
    // High byte = s >> sh, low byte = s << (8 - sh) truncated.
    mask_s       = {sprite_r, 8'h00} >> sh_s;
    lmask_s      = mask_s[15:8];
    rmask_s      = mask_s[7:0];
  end

  // Engine memory request for the current state.
  always_comb begin
    gpu_req_s   = 1'b0;
    gpu_we_s    = 1'b0;
    gpu_addr_s  = 12'h000;
    gpu_wdata_s = 8'h00;
    case (state_r)
      CLEAR: begin
        gpu_req_s  = 1'b1;
        gpu_we_s   = 1'b1;
        gpu_addr_s = FB_BASE + {4'h0, clr_cnt_r};
      end
      FETCH: begin
        gpu_req_s  = 1'b1;
        gpu_addr_s = offset_r + {8'h00, row_r};  // wraps at 12 bits
      end
      READ_L: begin
        gpu_req_s  = 1'b1;
        gpu_addr_s = left_addr_s;
      end
      READ_R: begin
        // With no shift the sprite fits in one byte: no right-byte access.
        gpu_req_s  = (sh_s != 3'd0);
        gpu_addr_s = right_addr_s;
      end
      WRITE_L: begin
        gpu_req_s   = 1'b1;
        gpu_we_s    = 1'b1;
        gpu_addr_s  = left_addr_s;
        gpu_wdata_s = left_old_r ^ lmask_s;
      end
      WRITE_R: begin
        gpu_req_s   = 1'b1;
        gpu_we_s    = 1'b1;
        gpu_addr_s  = right_addr_s;
        gpu_wdata_s = gpu_rdata_r ^ rmask_s;
      end
      default: begin
        gpu_req_s = 1'b0;
      end
    endcase
  end

  // Arbitration: CPU activity blocks the engine; engine steps when it has
  // no access to make or the port is free.
  always_comb begin
    cpu_busy_s = bus.read | bus.write;
    go_s       = ~gpu_req_s | ~cpu_busy_s;
    if (bus.write) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = bus.write_addr;
      mem_wdata_s = bus.write_data;
    end else begin
      mem_we_s    = gpu_req_s & gpu_we_s & ~cpu_busy_s;
      mem_addr_s  = gpu_addr_s;
      mem_wdata_s = gpu_wdata_s;
    end
  end

  // Single RAM write port shared by CPU and engine.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_addr_s] <= mem_wdata_s;
    end
  end

  // CPU read port: one-cycle latency, data held between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.read_data <= 8'h00;
      bus.read_ack  <= 1'b0;
    end else begin
      bus.read_ack <= bus.read;
      if (bus.read) begin
        bus.read_data <= mem[bus.read_addr];
      end
    end
  end

  // VGA read port: independent, one-cycle latency, data held when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vga_data <= 8'h00;
    end else if (bus.vga_read) begin
      bus.vga_data <= mem[bus.vga_addr];
    end
  end

  // Engine read data register, updated only by granted engine reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpu_rdata_r <= 8'h00;
    end else if (gpu_req_s && !gpu_we_s && !cpu_busy_s) begin
      gpu_rdata_r <= mem[gpu_addr_s];
    end
  end

  // Command FSM with registered ready/collision outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      bus.gpu_ready     <= 1'b1;
      bus.gpu_collision <= 1'b0;
      offset_r          <= 12'h000;
      x0_r              <= 6'd0;
      y0_r              <= 5'd0;
      len_r             <= 4'd0;
      row_r             <= 4'd0;
      clr_cnt_r         <= 8'd0;
      sprite_r          <= 8'h00;
      left_old_r        <= 8'h00;
      acc_r             <= 1'b0;
      upd_r             <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.gpu_cmd_submitted && bus.gpu_ready) begin
            offset_r      <= bus.gpu_draw_offset;
            x0_r          <= bus.gpu_draw_x[5:0];
            y0_r          <= bus.gpu_draw_y[4:0];
            len_r         <= bus.gpu_draw_length[3:0];
            row_r         <= 4'd0;
            clr_cnt_r     <= 8'd0;
            acc_r         <= 1'b0;
            bus.gpu_ready <= 1'b0;
            case (bus.gpu_cmd)
              4'd1: begin
                upd_r   <= 1'b1;
                state_r <= CLEAR;
              end
              4'd2: begin
                upd_r   <= 1'b1;
                state_r <= (bus.gpu_draw_length[3:0] == 4'd0) ? DONE : FETCH;
              end
              default: begin
                upd_r   <= 1'b0;          // NOP leaves collision untouched
                state_r <= DONE;
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          if (go_s) begin
            clr_cnt_r <= clr_cnt_r + 8'd1;
            if (clr_cnt_r == 8'hFF) begin
              state_r <= DONE;
            end
          end
        end
        FETCH: begin
          if (go_s) begin
            state_r <= READ_L;
          end
        end
        READ_L: begin
          if (go_s) begin
            sprite_r <= gpu_rdata_r;     // sprite byte read in FETCH
            state_r  <= READ_R;
          end
        end
        READ_R: begin
          if (go_s) begin
            left_old_r <= gpu_rdata_r;   // old left byte read in READ_L
            state_r    <= WRITE_L;
          end
        end
        WRITE_L: begin
          if (go_s) begin
            acc_r   <= acc_r | (|(left_old_r & lmask_s));
            state_r <= (sh_s != 3'd0) ? WRITE_R : NEXT;
          end
        end
        WRITE_R: begin
          if (go_s) begin
            acc_r   <= acc_r | (|(gpu_rdata_r & rmask_s));
            state_r <= NEXT;
          end
        end
        NEXT: begin
          row_r   <= row_r + 4'd1;
          state_r <= ((row_r + 4'd1) == len_r) ? DONE : FETCH;
        end
        DONE: begin
          bus.gpu_ready <= 1'b1;
          if (upd_r) begin
            bus.gpu_collision <= acc_r;
          end
          state_r <= IDLE;
        end
        default: begin
          bus.gpu_ready <= 1'b1;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_mem_gpu.sv
// ----------------------------------------------------------------------------
// tb_chip8_mem_gpu
// Directed self-checking bench for chip8_mem_gpu. Inputs are driven 1 ns
// after the rising edge; outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_chip8_mem_gpu;
  localparam logic [11:0] FB = 12'hF00;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  chip8_mem_gpu_if bus_if ();

  chip8_mem_gpu #(.FB_BASE(FB), .INIT_FILE("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    bus_if.write      = 1'b1;
    bus_if.write_addr = a;
    bus_if.write_data = d;
    tick();
    bus_if.write      = 1'b0;
  endtask

  task automatic cpu_read(input logic [11:0] a, output logic [7:0] d, output logic ak);
    bus_if.read      = 1'b1;
    bus_if.read_addr = a;
    tick();
    d                = bus_if.read_data;
    ak               = bus_if.read_ack;
    bus_if.read      = 1'b0;
  endtask

  task automatic fb_check(input string tag, input logic [7:0] idx, input logic [7:0] exp);
    logic [7:0] d;
    logic       ak;
    cpu_read(FB + {4'h0, idx}, d, ak);
    check_eq(tag, {23'd0, ak, d}, {23'd0, 1'b1, exp});
  endtask

  task automatic submit(input logic [3:0] cmd, input logic [11:0] off,
                        input logic [7:0] x, input logic [7:0] y, input logic [7:0] n);
    bus_if.gpu_cmd           = cmd;
    bus_if.gpu_draw_offset   = off;
    bus_if.gpu_draw_x        = x;
    bus_if.gpu_draw_y        = y;
    bus_if.gpu_draw_length   = n;
    bus_if.gpu_cmd_submitted = 1'b1;
    tick();
    bus_if.gpu_cmd_submitted = 1'b0;
    check_eq("busy_after_submit", bus_if.gpu_ready, 1'b0);
  endtask

  task automatic wait_ready(input int max, output int n);
    n = 0;
    while (!bus_if.gpu_ready && n < max) begin
      tick();
      n++;
    end
    check_eq("ready_timeout", bus_if.gpu_ready, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       ak;
    logic [7:0] orv;
    int         n;

    rst                      = 1'b1;
    bus_if.read              = 1'b0;
    bus_if.read_addr         = 12'h000;
    bus_if.write             = 1'b0;
    bus_if.write_addr        = 12'h000;
    bus_if.write_data        = 8'h00;
    bus_if.gpu_cmd           = 4'd0;
    bus_if.gpu_draw_offset   = 12'h000;
    bus_if.gpu_draw_x        = 8'd0;
    bus_if.gpu_draw_y        = 8'd0;
    bus_if.gpu_draw_length   = 8'd0;
    bus_if.gpu_cmd_submitted = 1'b0;
    bus_if.vga_read          = 1'b0;
    bus_if.vga_addr          = 12'h000;
    tick(); tick(); tick();
    check_eq("rst_read_ack", bus_if.read_ack, 1'b0);
    check_eq("rst_read_data", bus_if.read_data, 8'h00);
    check_eq("rst_vga_data", bus_if.vga_data, 8'h00);
    check_eq("rst_ready", bus_if.gpu_ready, 1'b1);
    check_eq("rst_collision", bus_if.gpu_collision, 1'b0);
    rst = 1'b0;
    tick();

    // CPU write then read, one-cycle ack, data held afterwards.
    cpu_write(12'h300, 8'hAB);
    cpu_read(12'h300, d, ak);
    check_eq("rd_ack", ak, 1'b1);
    check_eq("rd_data", d, 8'hAB);
    tick();
    check_eq("rd_ack_single", bus_if.read_ack, 1'b0);
    check_eq("rd_data_hold", bus_if.read_data, 8'hAB);

    // Same-cycle write and read of one address returns the old byte.
    bus_if.write = 1'b1; bus_if.write_addr = 12'h300; bus_if.write_data = 8'hCD;
    bus_if.read  = 1'b1; bus_if.read_addr  = 12'h300;
    tick();
    bus_if.write = 1'b0; bus_if.read = 1'b0;
    check_eq("rw_same_old", bus_if.read_data, 8'hAB);
    cpu_read(12'h300, d, ak);
    check_eq("rw_same_new", d, 8'hCD);

    // Fill framebuffer, then CLS.
    for (int i = 0; i < 256; i++) cpu_write(FB + i[11:0], 8'hFF);
    submit(4'd1, 12'h000, 8'd0, 8'd0, 8'd0);
    wait_ready(400, n);
    check_eq("cls_min_cycles", (n >= 255) ? 1 : 0, 1);
    orv = 8'h00;
    for (int i = 0; i < 256; i++) begin
      cpu_read(FB + i[11:0], d, ak);
      orv = orv | d;
    end
    check_eq("cls_all_zero", orv, 8'h00);
    check_eq("cls_collision", bus_if.gpu_collision, 1'b0);

    // Basic DRAW and collision on redraw.
    cpu_write(12'h050, 8'hF0);
    submit(4'd2, 12'h050, 8'd0, 8'd0, 8'd1);
    wait_ready(50, n);
    fb_check("draw1_fb0", 8'd0, 8'hF0);
    check_eq("draw1_coll", bus_if.gpu_collision, 1'b0);
    submit(4'd2, 12'h050, 8'd0, 8'd0, 8'd1);
    wait_ready(50, n);
    fb_check("draw2_fb0", 8'd0, 8'h00);
    check_eq("draw2_coll", bus_if.gpu_collision, 1'b1);

    // NOP: busy for one cycle, collision unchanged.
    submit(4'd0, 12'h000, 8'd0, 8'd0, 8'd0);
    tick();
    check_eq("nop_ready", bus_if.gpu_ready, 1'b1);
    check_eq("nop_coll_kept", bus_if.gpu_collision, 1'b1);

    // Length 16 == 0 mod 16: immediate completion, collision cleared.
    submit(4'd2, 12'h050, 8'd0, 8'd0, 8'd16);
    wait_ready(5, n);
    check_eq("len0_coll", bus_if.gpu_collision, 1'b0);
    fb_check("len0_fb0", 8'd0, 8'h00);

    // Both-axis wrap: x=60 (sh=4, byte 7), y=31, two rows of 0xFF.
    cpu_write(12'h060, 8'hFF);
    cpu_write(12'h061, 8'hFF);
    submit(4'd2, 12'h060, 8'd60, 8'd31, 8'd2);
    wait_ready(60, n);
    fb_check("wrap_fb255", 8'd255, 8'h0F);
    fb_check("wrap_fb248", 8'd248, 8'hF0);
    fb_check("wrap_fb7", 8'd7, 8'h0F);
    fb_check("wrap_fb0", 8'd0, 8'hF0);
    check_eq("wrap_coll", bus_if.gpu_collision, 1'b0);

    // x=67 -> x0=3, y=34 -> y0=2, sprite 0x81 on a cleared screen.
    submit(4'd1, 12'h000, 8'd0, 8'd0, 8'd0);
    wait_ready(400, n);
    cpu_write(12'h070, 8'h81);
    submit(4'd2, 12'h070, 8'd67, 8'd34, 8'd1);
    wait_ready(50, n);
    fb_check("sh3_fb16", 8'd16, 8'h10);
    fb_check("sh3_fb17", 8'd17, 8'h20);
    check_eq("sh3_coll", bus_if.gpu_collision, 1'b0);

    // Source address wrap 0xFFF -> 0x000, x=8 (sh=0, right byte untouched).
    cpu_write(12'h000, 8'h3C);
    submit(4'd2, 12'hFFF, 8'd8, 8'd5, 8'd2);
    wait_ready(60, n);
    fb_check("owrap_fb41", 8'd41, 8'h00);
    fb_check("owrap_fb49", 8'd49, 8'h3C);
    fb_check("owrap_fb50", 8'd50, 8'h00);
    check_eq("owrap_coll", bus_if.gpu_collision, 1'b0);

    // Continuous CPU reads during a DRAW: every read acked next cycle,
    // engine held off until the CPU releases the port.
    cpu_write(12'h080, 8'hAA);
    submit(4'd2, 12'h080, 8'd20, 8'd10, 8'd1);
    bus_if.read = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_if.read_addr = (i % 2 == 0) ? 12'h300 : 12'h050;
      tick();
      check_eq("burst_ack", bus_if.read_ack, 1'b1);
      check_eq("burst_data", bus_if.read_data, (i % 2 == 0) ? 8'hCD : 8'hF0);
    end
    bus_if.read = 1'b0;
    check_eq("burst_gpu_stalled", bus_if.gpu_ready, 1'b0);
    wait_ready(50, n);
    fb_check("burst_fb82", 8'd82, 8'h0A);
    fb_check("burst_fb83", 8'd83, 8'hA0);
    check_eq("burst_coll", bus_if.gpu_collision, 1'b0);

    // VGA read: one-cycle latency, holds when not enabled.
    bus_if.vga_read = 1'b1;
    bus_if.vga_addr = FB + 12'd82;
    tick();
    bus_if.vga_read = 1'b0;
    bus_if.vga_addr = FB + 12'd83;
    check_eq("vga_fb82", bus_if.vga_data, 8'h0A);
    tick();
    check_eq("vga_hold", bus_if.vga_data, 8'h0A);
    bus_if.vga_read = 1'b1;
    tick();
    bus_if.vga_read = 1'b0;
    check_eq("vga_fb83", bus_if.vga_data, 8'hA0);

    // Reset mid-CLS: engine idle again, partially cleared bytes remain.
    cpu_write(FB, 8'h55);
    cpu_write(FB + 12'd200, 8'h66);
    submit(4'd1, 12'h000, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_ready", bus_if.gpu_ready, 1'b1);
    fb_check("abort_fb0", 8'd0, 8'h00);
    fb_check("abort_fb200", 8'd200, 8'h66);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/chip8_mem_gpu.md
Name: chip8_mem_gpu

Overview:
CHIP-8 memory plus sprite/graphics engine. It holds the 4 KiB byte-addressed system RAM, including the 64x32 monochrome framebuffer. It executes clear-screen and XOR sprite-draw commands issued by the CPU core. It serves three requestors: a CPU load/store port, an internal GPU port, and an independent VGA scan-out read port.

Parameters:
FB_BASE, 12'hF00, base address of the 256-byte framebuffer (8 bytes per row, 32 rows).
INIT_FILE, "", hex image loaded into RAM at configuration (font at 0x000–0x04F, program at 0x200); empty = all zero.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
read  in  1  CPU read request
read_addr  in  12  CPU read address
read_data  out  8  CPU read data
read_ack  out  1  CPU read-complete pulse
write  in  1  CPU write strobe
write_addr  in  12  CPU write address
write_data  in  8  CPU write data
gpu_cmd  in  4  command: 0 = NOP, 1 = CLS, 2 = DRAW, others = NOP
gpu_draw_offset  in  12  sprite source address (I register)
gpu_draw_x  in  8  sprite X (pixels)
gpu_draw_y  in  8  sprite Y (pixels)
gpu_draw_length  in  8  sprite height in rows (N)
gpu_cmd_submitted  in  1  one-cycle command strobe
gpu_collision  out  1  VF result of the last DRAW
gpu_ready  out  1  engine idle, accepts a command
vga_read  in  1  VGA read enable
vga_addr  in  12  VGA read address
vga_data  out  8  VGA read data

Behaviour:
- Reset:
  - read_ack=0, read_data=0, vga_data=0, gpu_ready=1, gpu_collision=0, FSM=IDLE.
  - RAM contents are NOT altered by reset.
- CPU read:
  - read=1 in cycle N -> read_data=mem[read_addr] and read_ack=1 in cycle N+1.
  - read_ack is high for exactly one cycle per request cycle.
  - read_data holds its value until the next read.
- CPU write: write=1 -> mem[write_addr] updated at that clock edge. A same-cycle read of the same address returns the old data.
- VGA port:
  - vga_read=1 -> vga_data=mem[vga_addr] next cycle; otherwise vga_data holds.
  - Fully independent of the other ports; never stalls.
- Arbitration between CPU and GPU internal accesses:
  - The CPU port always wins; the GPU FSM stalls for that cycle and retries.
  - If the CPU and GPU write the same address in one cycle, the CPU data is stored.
- Command handshake:
  - A command is accepted only when gpu_cmd_submitted=1 and gpu_ready=1.
  - gpu_cmd, offset, x, y and length are latched on acceptance.
  - gpu_ready goes 0 the next cycle and returns to 1 when the command completes.
  - A strobe while busy is ignored.
  - A NOP completes in one cycle, leaving gpu_collision unchanged.
- FSM states: IDLE, CLEAR, FETCH, READ_L, READ_R, WRITE_L, WRITE_R, NEXT, DONE.
- CLS:
  - Writes 0 to FB_BASE..FB_BASE+255, one byte per cycle (256 cycles minimum).
  - Sets gpu_collision=0.
- DRAW (length 0 completes immediately with collision=0; length is used mod 16):
  - x0 = x mod 64, y0 = y mod 32, sh = x0[2:0], collision accumulator cleared.
  - For each row r in 0..N-1:
    - Sprite byte s = mem[offset+r]; the address wraps at 12 bits.
    - Row yr = (y0+r) mod 32 (vertical wrap).
    - Left byte address = FB_BASE + yr*8 + x0[5:3].
    - Right byte address = FB_BASE + yr*8 + ((x0[5:3]+1) mod 8) (horizontal wrap).
    - Left mask = s >> sh; right mask = (s << (8-sh)) truncated to 8 bits. When sh=0 the right byte is skipped.
    - Each target byte becomes old XOR mask. Collision accumulates when (old AND mask) != 0.
  - Framebuffer bit 7 of each byte is the leftmost pixel.
- gpu_collision updates only at DONE and is held until the next CLS/DRAW completes.
- Reset mid-command aborts it: FSM returns to IDLE and gpu_ready=1. Partially drawn bytes remain.

Test Plan:
- CPU write 0xAB to 0x300, then read 0x300 -> read_ack pulses one cycle after the request; read_data=0xAB.
- Fill the framebuffer with 0xFF, issue CLS -> gpu_ready low during the clear, then high; all 256 FB bytes=0; gpu_collision=0.
- Sprite 0xF0 at 0x050, DRAW x=0 y=0 N=1 -> mem[FB_BASE]=0xF0, collision=0. Repeat the same DRAW -> mem[FB_BASE]=0x00, collision=1.
- DRAW 0xFF at x=60 y=31 N=2 -> FB[31*8+7]=0x0F, FB[31*8+0]=0xF0, FB[7]=0x0F, FB[0]=0xF0 (both wraps), collision=0.
- DRAW x=67 (sh=3) with sprite 0x81 on an empty screen -> FB byte0=0x10, byte1=0x20.
- Continuous CPU reads during a DRAW -> every read is acked with the next-cycle latency; the DRAW still completes correctly. VGA reads of FB bytes return current contents with 1-cycle latency.
